// File: rtl/box_pixel_streamer_if.sv
// Frame-RAM read port plus the pixel-byte stream toward the bounding-box tracker.
interface box_pixel_streamer_if #(parameter int ADDR_W = 24);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [31:0]       out_data;
    logic              wr_en;
    logic              ready;

    modport master (output mem_rd_en, mem_addr, out_data, wr_en, input mem_rdata, ready);
    modport slave  (input mem_rd_en, mem_addr, out_data, wr_en, output mem_rdata, ready);
endinterface

// File: rtl/box_pixel_streamer.sv
// Streams one RGB frame from a byte-wide synchronous RAM as {value, index} words,
// preceded by a tracker clear word. One byte every 3 cycles when the sink is ready.
module box_pixel_streamer #(
    parameter int WIDTH       = 100,
    parameter int HEIGHT      = 100,
    parameter int ADDR_W      = 24,
    parameter int CLEAR_INDEX = 99999
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic start,
    output logic busy,
    output logic done,
    box_pixel_streamer_if.master bus
);
    localparam int                TOTAL      = WIDTH * HEIGHT * 3;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(TOTAL - 1);
    localparam logic [31:0]       IDLE_WORD  = {8'hFF, 24'd0};
    localparam logic [31:0]       CLEAR_WORD = {8'hFF, 24'(CLEAR_INDEX)};

    typedef enum logic [2:0] {IDLE, CLEAR, READ, WAIT, SEND, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       out_data;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= IDLE_WORD;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= CLEAR;
                    busy     <= 1'b1;
                    out_data <= CLEAR_WORD;
                end
                CLEAR: begin
                    // Drop the clear index straight away so it shows for exactly one
                    // cycle; the white filler word is never acted on by the tracker.
                    state     <= READ;
                    out_data  <= IDLE_WORD;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= idx;
                end
                READ: state <= WAIT;
                WAIT: begin
                    // out_data doubles as the byte register while the sink stalls.
                    state    <= SEND;
                    out_data <= {bus.mem_rdata, 24'(idx)};
                end
                SEND: if (bus.ready) begin
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= READ;
                        idx       <= idx + ADDR_W'(1);
                        mem_rd_en <= 1'b1;
                        mem_addr  <= idx + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en = mem_rd_en;
    assign bus.mem_addr  = mem_addr;
    assign bus.out_data  = out_data;
    assign bus.wr_en     = (state == SEND) && bus.ready;
endmodule
